// File: rtl/ets_pkg.sv
// Shared types and constants for the multi-route ticket seller:
// one-hot state encoding, display message codes, command decode,
// per-route fare table and the group-discount helper.
package ets_pkg;

  localparam int MAX_ROUTES = 15;

  typedef enum logic [8:0] {
    S_IDLE       = 9'b0_0000_0001,
    S_SOLD_OUT   = 9'b0_0000_0010,
    S_SHOW_AVAIL = 9'b0_0000_0100,
    S_ASK_QTY    = 9'b0_0000_1000,
    S_QTY_ERR    = 9'b0_0001_0000,
    S_SHOW_FARE  = 9'b0_0010_0000,
    S_WAIT_CARD  = 9'b0_0100_0000,
    S_LOW_BAL    = 9'b0_1000_0000,
    S_DONE       = 9'b1_0000_0000
  } state_t;

  localparam logic [3:0] MSG_IDLE       = 4'd1;
  localparam logic [3:0] MSG_SOLD_OUT   = 4'd2;
  localparam logic [3:0] MSG_SHOW_AVAIL = 4'd3;
  localparam logic [3:0] MSG_ASK_QTY    = 4'd4;
  localparam logic [3:0] MSG_QTY_ERR    = 4'd5;
  localparam logic [3:0] MSG_SHOW_FARE  = 4'd6;
  localparam logic [3:0] MSG_WAIT_CARD  = 4'd7;
  localparam logic [3:0] MSG_LOW_BAL    = 4'd8;
  localparam logic [3:0] MSG_DONE       = 4'd9;

  // Only the highest-priority strobe of a cycle is considered.
  typedef enum logic [2:0] {
    CMD_NONE, CMD_EXIT, CMD_CANCEL, CMD_CONFIRM, CMD_NEXT, CMD_DIGIT
  } cmd_t;

  // Single-ticket fare per route; route 0 has no fare.
  function automatic logic [15:0] fare_of(input logic [3:0] r);
    case (r)
      4'd1:    return 16'd500;
      4'd2:    return 16'd400;
      4'd3:    return 16'd800;
      4'd4:    return 16'd950;
      4'd5:    return 16'd650;
      4'd6:    return 16'd700;
      4'd7:    return 16'd200;
      4'd8:    return 16'd120;
      4'd9:    return 16'd300;
      4'd10:   return 16'd350;
      4'd11:   return 16'd450;
      4'd12:   return 16'd550;
      4'd13:   return 16'd600;
      4'd14:   return 16'd750;
      4'd15:   return 16'd850;
      default: return 16'd0;
    endcase
  endfunction

  // Ten percent off, rounded in the customer's disfavour (floor of the discount).
  function automatic logic [31:0] disc(input logic [31:0] gross);
    return gross - gross / 32'd10;
  endfunction

endpackage

// File: rtl/ets_multi_route_seller_if.sv
// Front-end bus of the ticket seller: keypad/card-reader strobes towards
// the seller and display/printer/card-writer results back.
interface ets_multi_route_seller_if #(parameter int BAL_W = 16);
  logic             digit_valid;
  logic [3:0]       digit;
  logic             next;
  logic             confirm;
  logic             cancel;
  logic             exit;
  logic             card_present;
  logic [BAL_W-1:0] card_balance;
  logic [3:0]       msg_no;
  logic [3:0]       route;
  logic [3:0]       qty;
  logic [5:0]       avail;
  logic [BAL_W-1:0] total_fare;
  logic [BAL_W-1:0] new_balance;
  logic             balance_we;
  logic             ticket_out;
  logic             timeout;

  modport master (
    output digit_valid, digit, next, confirm, cancel, exit, card_present, card_balance,
    input  msg_no, route, qty, avail, total_fare, new_balance, balance_we, ticket_out, timeout
  );

  modport slave (
    input  digit_valid, digit, next, confirm, cancel, exit, card_present, card_balance,
    output msg_no, route, qty, avail, total_fare, new_balance, balance_we, ticket_out, timeout
  );
endinterface

// File: rtl/ets_seat_store.sv
// Per-route seat inventory: combinational read by route number, one
// decrement port for completed sales, full reload on reset.
module ets_seat_store import ets_pkg::*; #(
  parameter int NUM_ROUTES = 9,
  parameter int SEATS      = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rd_route,
  output logic [5:0] rd_seats,
  input  logic       dec_en,
  input  logic [3:0] dec_route,
  input  logic [3:0] dec_qty
);

  logic [5:0] seats [0:MAX_ROUTES];

  // Invalid routes read as zero seats.
  always_comb begin
    rd_seats = 6'd0;
    if (rd_route != 4'd0 && rd_route <= 4'(NUM_ROUTES))
      rd_seats = seats[rd_route];
  end

  // Reload on reset, otherwise subtract a completed sale from its route.
  always_ff @(posedge clock) begin
    for (int i = 0; i <= MAX_ROUTES; i++) begin
      if (reset)
        seats[i] <= (i >= 1 && i <= NUM_ROUTES) ? 6'(SEATS) : 6'd0;
      else if (dec_en && dec_route == 4'(i))
        seats[i] <= seats[i] - {2'b00, dec_qty};
    end
  end

endmodule

// File: rtl/ets_multi_route_seller.sv
// Multi-route ticket seller: route/quantity selection from binary digits,
// fare display, card debit handshake and inactivity timeout.
// Build option: define GROUP_DISCOUNT_EN to take 10% off sales of 5+ tickets.
module ets_multi_route_seller import ets_pkg::*; #(
  parameter int NUM_ROUTES  = 9,
  parameter int SEATS       = 50,
  parameter int MAX_QTY     = 9,
  parameter int BAL_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                    clock,
  input logic                    reset,
  ets_multi_route_seller_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  state_t        state;
  logic [TW-1:0] timer;
  cmd_t          cmd;
  logic          accepted;
  logic          sale;
  logic          fire;
  logic          valid_route;
  logic          valid_qty;
  logic [5:0]    rd_seats;

  function automatic logic [BAL_W-1:0] calc_fare(input logic [3:0] r, input logic [3:0] q);
    logic [31:0] gross;
    logic [31:0] net;
    gross = 32'(fare_of(r)) * 32'(q);
`ifdef GROUP_DISCOUNT_EN
    net = (q >= 4'd5) ? disc(gross) : gross;
`else
    net = gross;
`endif
    return net[BAL_W-1:0];
  endfunction

  ets_seat_store #(
    .NUM_ROUTES(NUM_ROUTES),
    .SEATS     (SEATS)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .rd_route (bus.digit),
    .rd_seats (rd_seats),
    .dec_en   (sale),
    .dec_route(bus.route),
    .dec_qty  (bus.qty)
  );

  // Pick the single highest-priority strobe and decide whether it acts in this state.
  always_comb begin
    cmd = CMD_NONE;
    if (bus.exit)             cmd = CMD_EXIT;
    else if (bus.cancel)      cmd = CMD_CANCEL;
    else if (bus.confirm)     cmd = CMD_CONFIRM;
    else if (bus.next)        cmd = CMD_NEXT;
    else if (bus.digit_valid) cmd = CMD_DIGIT;

    valid_route = bus.digit != 4'd0 && bus.digit <= 4'(NUM_ROUTES);
    valid_qty   = bus.digit != 4'd0 && bus.digit <= 4'(MAX_QTY);
    sale        = cmd == CMD_CONFIRM && state == S_WAIT_CARD && bus.card_present &&
                  bus.card_balance >= bus.total_fare;

    accepted = 1'b0;
    case (cmd)
      CMD_EXIT:    accepted = 1'b1;
      CMD_CANCEL:  accepted = state inside {S_SHOW_AVAIL, S_QTY_ERR, S_SHOW_FARE, S_WAIT_CARD, S_LOW_BAL};
      CMD_CONFIRM: accepted = state == S_SHOW_FARE || (state == S_WAIT_CARD && bus.card_present);
      CMD_NEXT:    accepted = state == S_SHOW_AVAIL;
      CMD_DIGIT:   accepted = (state == S_IDLE && valid_route) || (state == S_ASK_QTY && valid_qty);
      default:     accepted = 1'b0;
    endcase

    fire = state != S_IDLE && !accepted && timer == TW'(TIMEOUT_CYC - 1);
  end

  // Sales FSM with registered display, fare, debit and pulse outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      timer           <= '0;
      bus.msg_no      <= MSG_IDLE;
      bus.route       <= 4'd0;
      bus.qty         <= 4'd0;
      bus.avail       <= 6'd0;
      bus.total_fare  <= '0;
      bus.new_balance <= '0;
      bus.balance_we  <= 1'b0;
      bus.ticket_out  <= 1'b0;
      bus.timeout     <= 1'b0;
    end else begin
      bus.balance_we <= 1'b0;
      bus.ticket_out <= 1'b0;
      bus.timeout    <= 1'b0;

      if (state == S_IDLE || accepted || fire) timer <= '0;
      else                                     timer <= timer + 1'b1;

      if (cmd == CMD_EXIT || fire) begin
        state          <= S_IDLE;
        bus.msg_no     <= MSG_IDLE;
        bus.route      <= 4'd0;
        bus.qty        <= 4'd0;
        bus.avail      <= 6'd0;
        bus.total_fare <= '0;
        bus.timeout    <= fire;
      end else if (accepted) begin
        case (cmd)
          CMD_CANCEL: begin
            state          <= S_ASK_QTY;
            bus.msg_no     <= MSG_ASK_QTY;
            bus.total_fare <= '0;
          end
          CMD_CONFIRM: begin
            if (state == S_SHOW_FARE) begin
              state      <= S_WAIT_CARD;
              bus.msg_no <= MSG_WAIT_CARD;
            end else if (sale) begin
              state           <= S_DONE;
              bus.msg_no      <= MSG_DONE;
              bus.new_balance <= bus.card_balance - bus.total_fare;
              bus.balance_we  <= 1'b1;
              bus.ticket_out  <= 1'b1;
              bus.avail       <= bus.avail - {2'b00, bus.qty};
            end else begin
              state      <= S_LOW_BAL;
              bus.msg_no <= MSG_LOW_BAL;
            end
          end
          CMD_NEXT: begin
            state      <= S_ASK_QTY;
            bus.msg_no <= MSG_ASK_QTY;
          end
          CMD_DIGIT: begin
            if (state == S_IDLE) begin
              bus.route <= bus.digit;
              bus.avail <= rd_seats;
              if (rd_seats == 6'd0) begin
                state      <= S_SOLD_OUT;
                bus.msg_no <= MSG_SOLD_OUT;
              end else begin
                state      <= S_SHOW_AVAIL;
                bus.msg_no <= MSG_SHOW_AVAIL;
              end
            end else begin
              bus.qty <= bus.digit;
              if ({2'b00, bus.digit} > bus.avail) begin
                state      <= S_QTY_ERR;
                bus.msg_no <= MSG_QTY_ERR;
              end else begin
                state          <= S_SHOW_FARE;
                bus.msg_no     <= MSG_SHOW_FARE;
                bus.total_fare <= calc_fare(bus.route, bus.digit);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ets_multi_route_seller.sv
// Bench for ets_multi_route_seller: directed vector table, hand-written
// sequences for sell-out, quantity error, timeout and mid-sale reset,
// then random strobes compared against a behavioural model.
module tb_ets_multi_route_seller;

  localparam int NR    = 9;
  localparam int SEATS = 50;
  localparam int MQ    = 9;
  localparam int BW    = 16;
  localparam int TO    = 40;

`ifdef GROUP_DISCOUNT_EN
  localparam int F5_R1 = 2250;
  localparam int F9_R1 = 4050;
  localparam int F9_R2 = 3240;
`else
  localparam int F5_R1 = 2500;
  localparam int F9_R1 = 4500;
  localparam int F9_R2 = 3600;
`endif

  logic clock = 1'b0;
  logic reset;

  ets_multi_route_seller_if #(.BAL_W(BW)) bus ();

  ets_multi_route_seller #(
    .NUM_ROUTES (NR),
    .SEATS      (SEATS),
    .MAX_QTY    (MQ),
    .BAL_W      (BW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rst; bit dv; int d; bit nx; bit cf; bit cn; bit ex; bit card; int bal;
  } stim_t;

  typedef struct {
    stim_t s;
    int msg; int route; int qty; int avail; int fare; int we; int tick; int nb;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_msg, m_route, m_qty, m_avail, m_fare, m_nb, m_we, m_tick, m_to, m_cnt;
  int m_seats [16];
  int fares [16] = '{0, 500, 400, 800, 950, 650, 700, 200, 120, 300, 350, 450, 550, 600, 750, 850};

  vec_t vq[$];

  function automatic int net_fare(int r, int q);
    int g;
    g = fares[r] * q;
`ifdef GROUP_DISCOUNT_EN
    if (q >= 5) g = g - g / 10;
`endif
    return g;
  endfunction

  function automatic stim_t st(bit rst, bit dv, int d, bit nx, bit cf, bit cn, bit ex, bit card, int bal);
    stim_t s;
    s.rst = rst; s.dv = dv; s.d = d; s.nx = nx; s.cf = cf; s.cn = cn; s.ex = ex; s.card = card; s.bal = bal;
    return s;
  endfunction

  function automatic stim_t s_idle();             return st(0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t s_rst();              return st(1, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t s_dig(int d);         return st(0, 1, d, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t s_next();             return st(0, 0, 0, 1, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t s_conf(bit c, int b); return st(0, 0, 0, 0, 1, 0, 0, c, b); endfunction
  function automatic stim_t s_cancel();           return st(0, 0, 0, 0, 0, 1, 0, 0, 0); endfunction
  function automatic stim_t s_exit();             return st(0, 0, 0, 0, 0, 0, 1, 0, 0); endfunction

  task automatic m_go_idle();
    m_msg = 1; m_route = 0; m_qty = 0; m_avail = 0; m_fare = 0;
  endtask

  // One clock of the seller described directly from its behavioural rules.
  task automatic model_step(input stim_t s);
    int cmd;
    int prev;
    bit act;
    m_we = 0; m_tick = 0; m_to = 0;
    if (s.rst) begin
      for (int i = 0; i < 16; i++) m_seats[i] = (i >= 1 && i <= NR) ? SEATS : 0;
      m_go_idle();
      m_nb = 0; m_cnt = 0;
      return;
    end
    prev = m_msg;
    act = 0;
    if (s.ex) cmd = 1;
    else if (s.cn) cmd = 2;
    else if (s.cf) cmd = 3;
    else if (s.nx) cmd = 4;
    else if (s.dv) cmd = 5;
    else cmd = 0;
    case (cmd)
      1: begin m_go_idle(); act = 1; end
      2: if (m_msg inside {3, 5, 6, 7, 8}) begin m_msg = 4; m_fare = 0; act = 1; end
      3: if (m_msg == 6) begin
           m_msg = 7; act = 1;
         end else if (m_msg == 7 && s.card) begin
           act = 1;
           if (s.bal < m_fare) m_msg = 8;
           else begin
             m_msg = 9; m_nb = s.bal - m_fare; m_we = 1; m_tick = 1;
             m_seats[m_route] -= m_qty;
             m_avail = m_seats[m_route];
           end
         end
      4: if (m_msg == 3) begin m_msg = 4; act = 1; end
      5: if (m_msg == 1 && s.d >= 1 && s.d <= NR) begin
           m_route = s.d; m_avail = m_seats[s.d]; m_msg = (m_avail == 0) ? 2 : 3; act = 1;
         end else if (m_msg == 4 && s.d >= 1 && s.d <= MQ) begin
           m_qty = s.d; act = 1;
           if (s.d > m_avail) m_msg = 5;
           else begin m_msg = 6; m_fare = net_fare(m_route, s.d); end
         end
      default: ;
    endcase
    if (prev == 1 || act) m_cnt = 0;
    else if (m_cnt == TO - 1) begin m_go_idle(); m_to = 1; m_cnt = 0; end
    else m_cnt++;
  endtask

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, sample 1 time unit later.
  task automatic apply(input stim_t s);
    reset            = s.rst;
    bus.digit_valid  = s.dv;
    bus.digit        = 4'(s.d);
    bus.next         = s.nx;
    bus.confirm      = s.cf;
    bus.cancel       = s.cn;
    bus.exit         = s.ex;
    bus.card_present = s.card;
    bus.card_balance = BW'(s.bal);
    @(posedge clock);
    model_step(s);
    #1;
  endtask

  task automatic cmp_model(string tag);
    chk({tag, "_msg"},   bus.msg_no,      m_msg);
    chk({tag, "_route"}, bus.route,       m_route);
    chk({tag, "_qty"},   bus.qty,         m_qty);
    chk({tag, "_avail"}, bus.avail,       m_avail);
    chk({tag, "_fare"},  bus.total_fare,  m_fare);
    chk({tag, "_nb"},    bus.new_balance, m_nb);
    chk({tag, "_we"},    bus.balance_we,  m_we);
    chk({tag, "_tick"},  bus.ticket_out,  m_tick);
    chk({tag, "_to"},    bus.timeout,     m_to);
  endtask

  task automatic add(stim_t s, int msg, int route, int qty, int avail, int fare, int we, int tick, int nb);
    vec_t v;
    v.s = s; v.msg = msg; v.route = route; v.qty = qty; v.avail = avail;
    v.fare = fare; v.we = we; v.tick = tick; v.nb = nb;
    vq.push_back(v);
  endtask

  // Full purchase from IDLE with the card presented on the final confirm.
  task automatic do_sale(int r, int q, int bal);
    apply(s_dig(r));
    apply(s_next());
    apply(s_dig(q));
    apply(s_conf(0, 0));
    apply(s_conf(1, bal));
  endtask

  initial begin
    int rem;
    stim_t s;
    string tag;

    // Directed vector table (starts right after reset)
    add(s_dig(3),         3, 3, 0, 50, 0,    0, 0, 0);
    add(s_next(),         4, 3, 0, 50, 0,    0, 0, 0);
    add(s_dig(2),         6, 3, 2, 50, 1600, 0, 0, 0);
    add(s_conf(0, 0),     7, 3, 2, 50, 1600, 0, 0, 0);
    add(s_conf(1, 5000),  9, 3, 2, 48, 1600, 1, 1, 3400);
    add(s_idle(),         9, 3, 2, 48, 1600, 0, 0, 3400);
    add(s_next(),         9, 3, 2, 48, 1600, 0, 0, 3400);
    add(s_exit(),         1, 0, 0, 0,  0,    0, 0, 3400);
    add(s_dig(10),        1, 0, 0, 0,  0,    0, 0, 3400);
    add(s_dig(0),         1, 0, 0, 0,  0,    0, 0, 3400);
    add(s_dig(3),         3, 3, 0, 48, 0,    0, 0, 3400);
    add(s_next(),         4, 3, 0, 48, 0,    0, 0, 3400);
    add(s_dig(0),         4, 3, 0, 48, 0,    0, 0, 3400);
    add(s_conf(1, 9000),  4, 3, 0, 48, 0,    0, 0, 3400);
    add(s_dig(4),         6, 3, 4, 48, 3200, 0, 0, 3400);
    add(s_cancel(),       4, 3, 4, 48, 0,    0, 0, 3400);
    add(s_dig(1),         6, 3, 1, 48, 800,  0, 0, 3400);
    add(s_conf(0, 0),     7, 3, 1, 48, 800,  0, 0, 3400);
    add(s_conf(0, 9999),  7, 3, 1, 48, 800,  0, 0, 3400);
    add(s_conf(1, 100),   8, 3, 1, 48, 800,  0, 0, 3400);
    add(s_cancel(),       4, 3, 1, 48, 0,    0, 0, 3400);
    add(s_dig(1),         6, 3, 1, 48, 800,  0, 0, 3400);
    add(s_conf(0, 0),     7, 3, 1, 48, 800,  0, 0, 3400);
    add(st(0, 0, 0, 0, 1, 0, 1, 1, 5000), 1, 0, 0, 0, 0, 0, 0, 3400);
    add(s_dig(1),         3, 1, 0, 50, 0,    0, 0, 3400);
    add(s_next(),         4, 1, 0, 50, 0,    0, 0, 3400);
    add(s_dig(5),         6, 1, 5, 50, F5_R1, 0, 0, 3400);
    add(st(0, 1, 2, 1, 0, 0, 0, 0, 0), 6, 1, 5, 50, F5_R1, 0, 0, 3400);
    add(s_exit(),         1, 0, 0, 0,  0,    0, 0, 3400);
    add(s_cancel(),       1, 0, 0, 0,  0,    0, 0, 3400);

    // Reset state
    apply(s_rst());
    chk("rst_msg",   bus.msg_no,      1);
    chk("rst_route", bus.route,       0);
    chk("rst_avail", bus.avail,       0);
    chk("rst_fare",  bus.total_fare,  0);
    chk("rst_nb",    bus.new_balance, 0);
    chk("rst_pulse", {bus.balance_we, bus.ticket_out, bus.timeout}, 0);
    apply(s_idle());

    foreach (vq[i]) begin
      apply(vq[i].s);
      tag = $sformatf("v%0d", i);
      chk({tag, "_msg"},   bus.msg_no,      vq[i].msg);
      chk({tag, "_route"}, bus.route,       vq[i].route);
      chk({tag, "_qty"},   bus.qty,         vq[i].qty);
      chk({tag, "_avail"}, bus.avail,       vq[i].avail);
      chk({tag, "_fare"},  bus.total_fare,  vq[i].fare);
      chk({tag, "_we"},    bus.balance_we,  vq[i].we);
      chk({tag, "_tick"},  bus.ticket_out,  vq[i].tick);
      chk({tag, "_nb"},    bus.new_balance, vq[i].nb);
    end

    // Sell route 1 down to zero; last sale uses a balance exactly equal to the fare
    rem = SEATS;
    for (int k = 0; k < 5; k++) begin
      do_sale(1, 9, 60000);
      rem -= 9;
      chk("so_tick",  bus.ticket_out,  1);
      chk("so_avail", bus.avail,       rem);
      chk("so_nb",    bus.new_balance, 60000 - F9_R1);
      apply(s_idle());
      chk("so_tick_low", bus.ticket_out, 0);
      apply(s_exit());
    end
    do_sale(1, 5, F5_R1);
    chk("so_eq_we",    bus.balance_we,  1);
    chk("so_eq_nb",    bus.new_balance, 0);
    chk("so_eq_avail", bus.avail,       0);
    apply(s_exit());
    apply(s_dig(1));
    chk("so_msg2",  bus.msg_no, 2);
    chk("so_av0",   bus.avail,  0);
    apply(s_next());
    chk("so_next_ign", bus.msg_no, 2);
    apply(s_exit());
    chk("so_exit", bus.msg_no, 1);

    // Route 2 down to 4 seats, then over-ask
    for (int k = 0; k < 5; k++) begin
      do_sale(2, 9, 60000);
      chk("r2_nb", bus.new_balance, 60000 - F9_R2);
      apply(s_exit());
    end
    do_sale(2, 1, 400);
    chk("r2_avail5to4", bus.avail, 4);
    apply(s_exit());
    apply(s_dig(2));
    chk("qe_avail", bus.avail, 4);
    apply(s_next());
    apply(s_dig(7));
    chk("qe_msg5", bus.msg_no, 5);
    apply(s_cancel());
    chk("qe_msg4", bus.msg_no, 4);
    apply(s_dig(4));
    chk("qe_msg6", bus.msg_no,     6);
    chk("qe_fare", bus.total_fare, 1600);
    apply(s_exit());

    // Inactivity timeout in ASK_QTY
    apply(s_dig(3));
    apply(s_next());
    for (int k = 0; k < TO - 1; k++) apply(s_idle());
    chk("to_before_msg", bus.msg_no,  4);
    chk("to_before_pls", bus.timeout, 0);
    apply(s_idle());
    chk("to_pulse", bus.timeout, 1);
    chk("to_msg",   bus.msg_no,  1);
    chk("to_route", bus.route,   0);
    apply(s_idle());
    chk("to_pulse_end", bus.timeout, 0);

    // Reset in the middle of a sale: no debit, inventory reloaded
    apply(s_dig(3));
    apply(s_next());
    apply(s_dig(2));
    apply(s_conf(0, 0));
    apply(st(1, 0, 0, 0, 1, 0, 0, 1, 5000));
    chk("mr_we",   bus.balance_we, 0);
    chk("mr_tick", bus.ticket_out, 0);
    chk("mr_msg",  bus.msg_no,     1);
    apply(s_dig(1));
    chk("mr_r1_reload", bus.avail, SEATS);
    apply(s_exit());
    apply(s_dig(2));
    chk("mr_r2_reload", bus.avail, SEATS);
    apply(s_exit());

    // Random strobes against the model
    for (int k = 0; k < 3000; k++) begin
      s.rst  = ($urandom_range(0, 399) == 0);
      s.dv   = ($urandom_range(0, 2) == 0);
      s.d    = $urandom_range(0, 15);
      s.nx   = ($urandom_range(0, 5) == 0);
      s.cf   = ($urandom_range(0, 5) == 0);
      s.cn   = ($urandom_range(0, 9) == 0);
      s.ex   = ($urandom_range(0, 24) == 0);
      s.card = ($urandom_range(0, 3) != 0);
      s.bal  = $urandom_range(0, 9000);
      apply(s);
      cmp_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
